regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32-entry general-purpose register file among NREQ write-back sources (ALU, load unit, multi-cycle unit). Each source has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers onto registered write-port outputs (rf_w/rf_waddr/rf_wdata). A pending-write bitmap is exported so decode logic can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin sharing of the register-file write port among NREQ
//            write-back sources, each with a one-entry holding buffer, plus a
//            pending-write bitmap for RAW hazard stalls.
//            Optional macro WBARB_R0_DROP_EN: writes to r0 are handshaked but
//            discarded before they reach a buffer.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 3,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*N-1:0]    req_data,
    output logic                 rf_w,
    output logic [AW-1:0]        rf_waddr,
    output logic [N-1:0]         rf_wdata,
    output logic [2:0]           grant_id,
    output logic [2**AW-1:0]     pending,
    output logic                 busy
);

    localparam logic [2:0] c_rr_init = 3'(NREQ - 1);

    logic [NREQ-1:0] hold_valid_q, hold_valid_d;
    logic [AW-1:0]   hold_addr_q [NREQ];
    logic [AW-1:0]   hold_addr_d [NREQ];
    logic [N-1:0]    hold_data_q [NREQ];
    logic [N-1:0]    hold_data_d [NREQ];
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            rf_w_q, rf_w_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [N-1:0]    rf_wdata_q, rf_wdata_d;
    logic [2:0]      grant_id_q, grant_id_d;

    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] load;
    logic [2:0]      win_id;
    logic [AW-1:0]   win_addr;
    logic [N-1:0]    win_data;

    // Visit buffers in order rr_ptr+1, rr_ptr+2, ... (mod NREQ); first valid wins.
    always_comb begin
        int pos;
        grant    = '0;
        win_id   = '0;
        win_addr = '0;
        win_data = '0;
        pos      = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr_q) + 1 + k;
            if (pos >= NREQ) pos = pos - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == pos && hold_valid_q[i] && grant == '0) begin
                    grant[i] = 1'b1;
                    win_id   = 3'(i);
                    win_addr = hold_addr_q[i];
                    win_data = hold_data_q[i];
                end
            end
        end
    end

    assign req_ready = ~hold_valid_q | grant;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
`ifdef WBARB_R0_DROP_EN
            load[i] = req_valid[i] & req_ready[i] & (req_addr[i*AW +: AW] != '0);
`else
            load[i] = req_valid[i] & req_ready[i];
`endif
        end
    end

    // A grant frees the slot; a same-cycle load refills it with the new entry.
    always_comb begin
        hold_valid_d = hold_valid_q & ~grant;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < NREQ; i++) begin
            if (load[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_addr_d[i]  = req_addr[i*AW +: AW];
                hold_data_d[i]  = req_data[i*N +: N];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_w_d     = |grant;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        if (|grant) begin
            rr_ptr_d   = win_id;
            rf_waddr_d = win_addr;
            rf_wdata_d = win_data;
            grant_id_d = win_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_addr_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
            rr_ptr_q   <= c_rr_init;
            rf_w_q     <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            rf_w_q       <= rf_w_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            grant_id_q   <= grant_id_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < 2**AW; r++) begin
            if (rf_w_q && rf_waddr_q == AW'(r)) pending[r] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (hold_valid_q[i] && hold_addr_q[i] == AW'(r)) pending[r] = 1'b1;
            end
        end
    end

    assign busy     = (|hold_valid_q) | rf_w_q;
    assign rf_w     = rf_w_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed vector bench for regfile_wb_arbiter (N=8, NREQ=3, AW=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 3;
    localparam int AW   = 5;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0]  req_data;
    logic               rf_w;
    logic [AW-1:0]      rf_waddr;
    logic [N-1:0]       rf_wdata;
    logic [2:0]         grant_id;
    logic [2**AW-1:0]   pending;
    logic               busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*N-1:0]  data;
        logic               exp_w;
        logic [AW-1:0]      exp_addr;
        logic [N-1:0]       exp_data;
        logic [2:0]         exp_gid;
        logic [NREQ-1:0]    exp_ready;
        logic [31:0]        exp_pend;
        logic               exp_busy;
    } vec_t;

    vec_t vecs[$];

    regfile_wb_arbiter #(.N(N), .NREQ(NREQ), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_w      (rf_w),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs: valid, addr of req 2/1/0, data of req 2/1/0; then expected outputs after the edge.
    task automatic add(input logic [2:0] v,
                       input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                       input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                       input logic w, input logic [4:0] wa, input logic [7:0] wd,
                       input logic [2:0] gid, input logic [2:0] rdy,
                       input logic [31:0] pend, input logic bsy);
        vec_t t;
        t.valid = v;      t.addr = {a2, a1, a0}; t.data = {d2, d1, d0};
        t.exp_w = w;      t.exp_addr = wa;       t.exp_data = wd;
        t.exp_gid = gid;  t.exp_ready = rdy;     t.exp_pend = pend;
        t.exp_busy = bsy;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                        input logic [2:0] gid, input logic [2:0] rdy,
                        input logic [31:0] pend, input logic bsy);
        add(3'b000, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, w, wa, wd, gid, rdy, pend, bsy);
    endtask

    task automatic check_outputs(input string tag, input vec_t t);
        chk({tag, " rf_w"},      32'(rf_w),      32'(t.exp_w));
        chk({tag, " rf_waddr"},  32'(rf_waddr),  32'(t.exp_addr));
        chk({tag, " rf_wdata"},  32'(rf_wdata),  32'(t.exp_data));
        chk({tag, " grant_id"},  32'(grant_id),  32'(t.exp_gid));
        chk({tag, " req_ready"}, 32'(req_ready), 32'(t.exp_ready));
        chk({tag, " pending"},   pending,        t.exp_pend);
        chk({tag, " busy"},      32'(busy),      32'(t.exp_busy));
    endtask

    initial begin
        vec_t rst_exp;

        // Contention from reset (rr_ptr=2): grants 0,1,2 on consecutive cycles.
        add(3'b111, 5'd3, 5'd2, 5'd1, 8'h33, 8'h22, 8'h11, 1'b0, 5'd0, 8'h00, 3'd0, 3'b001, 32'h0000_000E, 1'b1);
        idle(1'b1, 5'd1, 8'h11, 3'd0, 3'b011, 32'h0000_000E, 1'b1);
        idle(1'b1, 5'd2, 8'h22, 3'd1, 3'b111, 32'h0000_000C, 1'b1);
        idle(1'b1, 5'd3, 8'h33, 3'd2, 3'b111, 32'h0000_0008, 1'b1);
        // Same address r9 from req 0 and req 2: req 0 first, req 2 value last.
        add(3'b101, 5'd9, 5'd0, 5'd9, 8'h02, 8'h00, 8'h01, 1'b0, 5'd3, 8'h33, 3'd2, 3'b011, 32'h0000_0200, 1'b1);
        idle(1'b1, 5'd9, 8'h01, 3'd0, 3'b111, 32'h0000_0200, 1'b1);
        idle(1'b1, 5'd9, 8'h02, 3'd2, 3'b111, 32'h0000_0200, 1'b1);
        idle(1'b0, 5'd9, 8'h02, 3'd2, 3'b111, 32'h0000_0000, 1'b0);
        // Single uncontended write: r5 <= A5.
        add(3'b001, 5'd0, 5'd0, 5'd5, 8'h00, 8'h00, 8'hA5, 1'b0, 5'd9, 8'h02, 3'd2, 3'b111, 32'h0000_0020, 1'b1);
        idle(1'b1, 5'd5, 8'hA5, 3'd0, 3'b111, 32'h0000_0020, 1'b1);
        idle(1'b0, 5'd5, 8'hA5, 3'd0, 3'b111, 32'h0000_0000, 1'b0);
        // Streaming from req 1: addr 7..14, data 70..77, no bubbles.
        add(3'b010, 5'd0, 5'd7, 5'd0, 8'h00, 8'h70, 8'h00, 1'b0, 5'd5, 8'hA5, 3'd0, 3'b111, 32'h0000_0080, 1'b1);
        for (int k = 1; k < 8; k++) begin
            add(3'b010, 5'd0, 5'(7 + k), 5'd0, 8'h00, 8'(8'h70 + k), 8'h00,
                1'b1, 5'(6 + k), 8'(8'h6F + k), 3'd1, 3'b111,
                (32'd1 << (7 + k)) | (32'd1 << (6 + k)), 1'b1);
        end
        idle(1'b1, 5'd14, 8'h77, 3'd1, 3'b111, 32'h0000_4000, 1'b1);
        idle(1'b0, 5'd14, 8'h77, 3'd1, 3'b111, 32'h0000_0000, 1'b0);
        // r0 write from req 1.
`ifdef WBARB_R0_DROP_EN
        add(3'b010, 5'd0, 5'd0, 5'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 5'd14, 8'h77, 3'd1, 3'b111, 32'h0000_0000, 1'b0);
        idle(1'b0, 5'd14, 8'h77, 3'd1, 3'b111, 32'h0000_0000, 1'b0);
`else
        add(3'b010, 5'd0, 5'd0, 5'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 5'd14, 8'h77, 3'd1, 3'b111, 32'h0000_0001, 1'b1);
        idle(1'b1, 5'd0, 8'hFF, 3'd1, 3'b111, 32'h0000_0001, 1'b1);
        idle(1'b0, 5'd0, 8'hFF, 3'd1, 3'b111, 32'h0000_0000, 1'b0);
`endif

        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_exp = '{valid: '0, addr: '0, data: '0, exp_w: 1'b0, exp_addr: '0, exp_data: '0,
                    exp_gid: '0, exp_ready: 3'b111, exp_pend: '0, exp_busy: 1'b0};
        check_outputs("reset", rst_exp);
        reset = 1'b0;

        foreach (vecs[j]) begin
            @(negedge clk);
            req_valid = vecs[j].valid;
            req_addr  = vecs[j].addr;
            req_data  = vecs[j].data;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", j), vecs[j]);
        end

        // Reset mid-operation: fill all buffers, reset, confirm nothing issues afterwards.
        @(negedge clk);
        req_valid = 3'b111;
        req_addr  = {5'd20, 5'd21, 5'd22};
        req_data  = {8'hC3, 8'hC2, 8'hC1};
        @(posedge clk);
        #1;
        chk("midrst busy before", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        #1;
        check_outputs("midrst async", rst_exp);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("postrst%0d", c), rst_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
